data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-through, no-write-allocate data cache that answers the pipeline's MEM-stage load/store requests and fronts a slower backing data memory. It drives the `hit` signal consumed by the pipeline registers: `hit`=1 lets the pipeline advance, and `hit`=0 stalls every stage. On the CPU side it is the responder to the pipeline's memory accesses. On the memory side it is the initiator of a req/ready handshake.

## Interface
- `LINES`, 16: number of one-word lines; power of two, ≥2.
- `IDX_W`, 4: log2(`LINES`).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  load request from the EX/MEM control bits.
- `mem_write`  in  1  store request from the EX/MEM control bits.
- `address`  in  32  byte address (ALU result); bits [1:0] are ignored.
- `write_data`  in  32  store data (RD2 from EX/MEM).
- `read_data`  out  32  load data; valid when `hit`=1 and `mem_read`=1.
- `hit`  out  1  1 = access complete or no access; 0 = stall pipeline.
- `mem_req`  out  1  backing-memory request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`=1.
- `mem_addr`  out  32  word-aligned backing address ([1:0]=0).
- `mem_wdata`  out  32  backing write data.
- `mem_rdata`  in  32  backing read data; valid with `mem_ready`.
- `mem_ready`  in  1  backing memory done; single-cycle pulse.
- `read_hits`  out  32  count of loads served without a fill.
- `read_misses`  out  32  count of fills started.

## Operation
- Address split: index = `address[IDX_W+1:2]`; tag = `address[31:IDX_W+2]`.
- Storage per line: valid bit, tag, 32-bit data word.
- A line hits when it is valid and its stored tag equals the request tag.
- If `mem_read` and `mem_write` are both 1, the request is a store and the read is ignored.
- The block has four states: IDLE, FILL, WRITE, DONE.
- IDLE, no request:
  - `hit`=1.
  - `read_data`=0.
- IDLE, load that hits:
  - `hit`=1 and `read_data`=line data, both combinational in the same cycle.
  - `read_hits` increments at the edge.
- IDLE, load that misses:
  - `hit`=0.
  - Latch the word address, go to FILL.
  - `read_misses` increments.
- IDLE, store:
  - `hit`=0.
  - Latch the address and `write_data`, go to WRITE.
- FILL:
  - Drive `mem_req`=1, `mem_we`=0.
  - On `mem_ready`: write `mem_rdata`, the tag and valid=1 into the line, go to IDLE.
  - The retried lookup in IDLE then hits. The fill itself does not count as a read hit; the following IDLE cycle counts one.
- WRITE:
  - Drive `mem_req`=1, `mem_we`=1.
  - On `mem_ready`: if the line hits on the latched tag, update its data (no-write-allocate otherwise); go to DONE.
- DONE:
  - `hit`=1 for exactly one cycle so the store retires once.
  - Then go to IDLE.
- `hit`=0 in FILL and WRITE.
- `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` are registered and held constant until `mem_ready` is sampled.
- Counters wrap modulo 2^32.

## Timing
- Reset values:
  - state = IDLE.
  - All valid bits = 0.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `read_hits`=0, `read_misses`=0.
  - `read_data`=0.
  - `hit` is combinational from inputs (1 when idle).
- Load hit: zero stall cycles.
- Load miss with memory latency L (`mem_ready` L cycles after `mem_req` rises, L≥1):
  - `hit`=0 for L+1 cycles (detect cycle plus L FILL cycles).
  - Data is returned in the following IDLE cycle.
- Store: `hit`=0 for L+1 cycles, then `hit`=1 in DONE.
- `mem_req` rises on the edge leaving IDLE and falls on the edge at which `mem_ready`=1 is sampled.
- `mem_ready` is ignored while `mem_req`=0.
- Inputs are assumed stable while `hit`=0, because the pipeline is stalled.
- `rst` mid-transaction:
  - Immediate return to IDLE, with all valid bits and both counters cleared.
  - `mem_req` drops asynchronously.
  - A late `mem_ready` is ignored.
- Index aliasing: a fill to an index overwrites any previous tag there.

## Test plan
- Reset: assert `rst` → `mem_req`=0, counters 0. Load from 0x40 → miss, `hit`=0.
- Load miss then hit, L=3 (`mem_rdata`=0xDEADBEEF):
  - Load 0x40 → `hit`=0 for 4 cycles, `mem_addr`=0x40 `mem_we`=0.
  - Then `hit`=1 with `read_data`=0xDEADBEEF.
  - A repeat load of 0x40 has zero stall; `read_hits`=2, `read_misses`=1.
- Store hit: after a fill of 0x40, store 0x12345678 to 0x40 (L=3):
  - `mem_we`=1, `mem_wdata`=0x12345678, `hit`=0 for 4 cycles, then DONE `hit`=1 for exactly 1 cycle.
  - A following load of 0x40 returns 0x12345678 with no stall.
- Store miss, no-allocate: store to 0x80 (index 0, empty) → a memory write occurs; a following load of 0x80 misses (`read_misses` increments).
- Conflict: load 0x40 then 0x440 (same index 0, different tag) → both miss. A reload of 0x40 misses again.
- Reset mid-fill: `rst` pulses during FILL, and `mem_ready` arrives a cycle later → `mem_req`=0, state IDLE, the line stays invalid, and the counters stay 0.

Source files
------------

// File: rtl/data_cache.sv
// data_cache
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// It serves MEM-stage loads and stores and stalls the pipeline (hit=0) while
// it talks to the backing memory over a req/ready handshake.
//
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   mem_read, mem_write      pipeline load/store request (both set = store)
//   address, write_data      byte address (bits [1:0] ignored) and store data
//   read_data, hit           load data and complete/stall indication
//   mem_req, mem_we          backing-memory request and direction (1 = write)
//   mem_addr, mem_wdata      registered word-aligned address and write data
//   mem_rdata, mem_ready     backing read data and single-cycle completion
//   read_hits, read_misses   load-hit and fill counters (wrap at 2^32)
module data_cache #(
    parameter int LINES = 16,
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] read_hits,
    output logic [31:0] read_misses
);

    localparam int TAG_W = 30 - IDX_W;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        DONE
    } stateT;

    stateT state;
    stateT nextState;

    logic [LINES-1:0] validBits;
    logic [TAG_W-1:0] tagMem  [LINES];
    logic [31:0]      dataMem [LINES];

    logic [IDX_W-1:0] reqIdx;
    logic [TAG_W-1:0] reqTag;
    logic [IDX_W-1:0] memIdx;
    logic [TAG_W-1:0] memTag;
    logic             isStore;
    logic             isLoad;
    logic             lookupHit;
    logic             latchedHit;
    logic             unusedAddrBits;

    assign reqIdx = address[IDX_W+1:2];
    assign reqTag = address[31:IDX_W+2];

    // The registered memory address doubles as the latched request address,
    // so fills and write-through updates index the line from it.
    assign memIdx = mem_addr[IDX_W+1:2];
    assign memTag = mem_addr[31:IDX_W+2];

    // A simultaneous read and write is treated as a store.
    assign isStore = mem_write;
    assign isLoad  = mem_read & ~mem_write;

    assign lookupHit  = validBits[reqIdx] && (tagMem[reqIdx] == reqTag);
    assign latchedHit = validBits[memIdx] && (tagMem[memIdx] == memTag);

    assign unusedAddrBits = ^address[1:0];

    // Next-state and pipeline-facing outputs; a load hit answers in the same cycle.
    always_comb begin
        nextState = state;
        hit       = 1'b1;
        read_data = 32'h0;
        case (state)
            IDLE: begin
                if (isStore) begin
                    hit       = 1'b0;
                    nextState = WRITE;
                end else if (isLoad) begin
                    if (lookupHit) begin
                        read_data = dataMem[reqIdx];
                    end else begin
                        hit       = 1'b0;
                        nextState = FILL;
                    end
                end
            end
            FILL: begin
                hit = 1'b0;
                if (mem_ready) begin
                    nextState = IDLE;
                end
            end
            WRITE: begin
                hit = 1'b0;
                if (mem_ready) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State, valid bits, memory handshake registers and counters. Reset drops
    // mem_req immediately so a late mem_ready lands in IDLE and is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            validBits   <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wdata   <= 32'h0;
            read_hits   <= 32'h0;
            read_misses <= 32'h0;
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (isStore) begin
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {address[31:2], 2'b00};
                        mem_wdata <= write_data;
                    end else if (isLoad) begin
                        if (lookupHit) begin
                            read_hits <= read_hits + 32'd1;
                        end else begin
                            mem_req     <= 1'b1;
                            mem_we      <= 1'b0;
                            mem_addr    <= {address[31:2], 2'b00};
                            read_misses <= read_misses + 32'd1;
                        end
                    end
                end
                FILL: begin
                    if (mem_ready) begin
                        mem_req           <= 1'b0;
                        validBits[memIdx] <= 1'b1;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tag and data arrays need no reset because the valid bits guard them.
    // A store only updates a line it already hits (no write-allocate).
    always_ff @(posedge clk) begin
        if (state == FILL && mem_ready) begin
            tagMem[memIdx]  <= memTag;
            dataMem[memIdx] <= mem_rdata;
        end else if (state == WRITE && mem_ready && latchedHit) begin
            dataMem[memIdx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache
// Scoreboard bench for data_cache. Directed accesses push their expected load
// data and expected backing-memory requests into queues; a monitor pops and
// compares whenever the cache completes a load or raises a new mem_req.
// A small backing-memory responder answers requests after a fixed latency.
module tb_data_cache;

    localparam int LAT = 3;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } reqT;

    logic        clk;
    logic        rst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        hit;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] read_hits;
    logic [31:0] read_misses;

    int checks = 0;
    int errors = 0;

    logic [31:0] expLoad [$];
    reqT         expReq  [$];
    logic [31:0] backing [logic [31:0]];

    logic manualMode  = 1'b0;
    logic injectReady = 1'b0;
    logic prevReq     = 1'b0;
    int   stalls;

    data_cache #(.LINES(16), .IDX_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .address(address),
        .write_data(write_data),
        .read_data(read_data),
        .hit(hit),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .read_hits(read_hits),
        .read_misses(read_misses)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one access starting just after a rising edge, counts the stall
    // cycles until hit=1, then removes the request after the completing edge.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] data, output int stallCount);
        bit done = 1'b0;
        mem_read   = rd;
        mem_write  = wr;
        address    = addr;
        write_data = data;
        stallCount = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (hit) done = 1'b1;
            else stallCount++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accessTimeout: got no hit after 50 cycles, expected completion");
        end
        @(posedge clk);
        #1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
    endtask

    // Backing memory: raises mem_ready so it is sampled LAT edges after mem_req rises.
    initial begin
        int waitCnt;
        waitCnt   = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (manualMode) begin
                waitCnt   = 0;
                mem_ready = injectReady;
            end else if (mem_req) begin
                waitCnt++;
                if (waitCnt == LAT) begin
                    waitCnt   = 0;
                    mem_ready = 1'b1;
                    if (mem_we) backing[mem_addr] = mem_wdata;
                    else mem_rdata = backing.exists(mem_addr) ? backing[mem_addr] : 32'h0;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    // Monitor: completed loads and newly raised memory requests.
    always @(negedge clk) begin
        if (rst) begin
            prevReq = 1'b0;
        end else begin
            if (hit && mem_read && !mem_write) begin
                if (expLoad.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedLoad: got data 0x%08h, expected no load response", read_data);
                end else begin
                    checkOutput("loadData", read_data, expLoad.pop_front());
                end
            end
            if (mem_req && !prevReq) begin
                if (expReq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedReq: got request addr 0x%08h we %0b, expected none", mem_addr, mem_we);
                end else begin
                    reqT r;
                    r = expReq.pop_front();
                    checkOutput("memWe", {31'h0, mem_we}, {31'h0, r.we});
                    checkOutput("memAddr", mem_addr, r.addr);
                    if (r.we) checkOutput("memWdata", mem_wdata, r.wdata);
                end
            end
            prevReq = mem_req;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        backing[32'h40]  = 32'hDEADBEEF;
        backing[32'h440] = 32'hCAFEF00D;
        backing[32'h44]  = 32'h0BADF00D;
        backing[32'h48]  = 32'h77778888;

        rst        = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstMemReq", {31'h0, mem_req}, 32'h0);
        checkOutput("rstMemWe", {31'h0, mem_we}, 32'h0);
        checkOutput("rstMemAddr", mem_addr, 32'h0);
        checkOutput("rstMemWdata", mem_wdata, 32'h0);
        checkOutput("rstReadHits", read_hits, 32'h0);
        checkOutput("rstReadMisses", read_misses, 32'h0);
        checkOutput("rstHit", {31'h0, hit}, 32'h1);
        checkOutput("rstReadData", read_data, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] load miss then hit");
        expReq.push_back('{1'b0, 32'h40, 32'h0});
        expLoad.push_back(32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, stalls);
        checkOutput("missStall", stalls, 32'd4);
        expLoad.push_back(32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, stalls);
        checkOutput("hitStall", stalls, 32'd0);
        checkOutput("readHits1", read_hits, 32'd2);
        checkOutput("readMisses1", read_misses, 32'd1);

        $display("[TB] store hit then load");
        expReq.push_back('{1'b1, 32'h40, 32'h12345678});
        applyStimulus(1'b0, 1'b1, 32'h40, 32'h12345678, stalls);
        checkOutput("storeStall", stalls, 32'd4);
        expLoad.push_back(32'h12345678);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, stalls);
        checkOutput("loadAfterStoreStall", stalls, 32'd0);

        $display("[TB] store miss, no allocate");
        expReq.push_back('{1'b1, 32'h80, 32'hA5A5A5A5});
        applyStimulus(1'b0, 1'b1, 32'h80, 32'hA5A5A5A5, stalls);
        checkOutput("storeMissStall", stalls, 32'd4);
        expReq.push_back('{1'b0, 32'h80, 32'h0});
        expLoad.push_back(32'hA5A5A5A5);
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, stalls);
        checkOutput("noAllocStall", stalls, 32'd4);
        expReq.push_back('{1'b0, 32'h40, 32'h0});
        expLoad.push_back(32'h12345678);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, stalls);
        checkOutput("readHits2", read_hits, 32'd5);
        checkOutput("readMisses2", read_misses, 32'd3);

        $display("[TB] index conflict");
        expReq.push_back('{1'b0, 32'h440, 32'h0});
        expLoad.push_back(32'hCAFEF00D);
        applyStimulus(1'b1, 1'b0, 32'h440, 32'h0, stalls);
        checkOutput("conflictStall", stalls, 32'd4);
        expReq.push_back('{1'b0, 32'h40, 32'h0});
        expLoad.push_back(32'h12345678);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, stalls);
        checkOutput("reloadStall", stalls, 32'd4);
        checkOutput("readHits3", read_hits, 32'd7);
        checkOutput("readMisses3", read_misses, 32'd5);

        $display("[TB] separate index and read+write as store");
        expReq.push_back('{1'b0, 32'h44, 32'h0});
        expLoad.push_back(32'h0BADF00D);
        applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, stalls);
        expLoad.push_back(32'h12345678);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, stalls);
        checkOutput("otherIndexKeepsLine", stalls, 32'd0);
        expReq.push_back('{1'b1, 32'h44, 32'h11112222});
        applyStimulus(1'b1, 1'b1, 32'h44, 32'h11112222, stalls);
        checkOutput("rwStoreStall", stalls, 32'd4);
        expLoad.push_back(32'h11112222);
        applyStimulus(1'b1, 1'b0, 32'h44, 32'h0, stalls);
        checkOutput("rwLoadStall", stalls, 32'd0);
        checkOutput("readHits4", read_hits, 32'd10);
        checkOutput("readMisses4", read_misses, 32'd6);

        $display("[TB] reset during fill");
        manualMode  = 1'b1;
        injectReady = 1'b0;
        expReq.push_back('{1'b0, 32'h48, 32'h0});
        mem_read = 1'b1;
        address  = 32'h48;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        checkOutput("fillReqHigh", {31'h0, mem_req}, 32'h1);
        rst      = 1'b1;
        mem_read = 1'b0;
        address  = 32'h0;
        #1;
        checkOutput("asyncReqDrop", {31'h0, mem_req}, 32'h0);
        #1;
        rst         = 1'b0;
        injectReady = 1'b1;
        @(posedge clk);
        #1;
        injectReady = 1'b0;
        @(posedge clk);
        #1;
        manualMode = 1'b0;
        checkOutput("lateReadyMemReq", {31'h0, mem_req}, 32'h0);
        checkOutput("lateReadyHit", {31'h0, hit}, 32'h1);
        checkOutput("rstMidHits", read_hits, 32'h0);
        checkOutput("rstMidMisses", read_misses, 32'h0);
        expReq.push_back('{1'b0, 32'h48, 32'h0});
        expLoad.push_back(32'h77778888);
        applyStimulus(1'b1, 1'b0, 32'h48, 32'h0, stalls);
        checkOutput("lineInvalidStall", stalls, 32'd4);
        expReq.push_back('{1'b0, 32'h40, 32'h0});
        expLoad.push_back(32'h12345678);
        applyStimulus(1'b1, 1'b0, 32'h40, 32'h0, stalls);
        checkOutput("validClearedStall", stalls, 32'd4);
        checkOutput("readHits5", read_hits, 32'd2);
        checkOutput("readMisses5", read_misses, 32'd2);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("loadQueueDrained", expLoad.size(), 32'd0);
        checkOutput("reqQueueDrained", expReq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
